// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encoding, fetch phase type.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    // Instruction opcodes, shared with the controller and the ALU.
    typedef enum logic [OP_W-1:0] {
        HLT  = 3'b000,
        SKZ  = 3'b001,
        ADD  = 3'b010,
        ANDD = 3'b011,
        XORR = 3'b100,
        LDA  = 3'b101,
        STO  = 3'b110,
        JMP  = 3'b111
    } opcode_t;

    // Which instruction byte the next LOAD_IR capture lands in.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } fetch_phase_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter with INC_PC rising-edge detect, increment/load, and next-PC lookahead.
// Latency: pc updates one edge after a strobe rise; pc_view shows the new value in the rise cycle.
// Backpressure: none; a held strobe produces exactly one action.
//
// Ports: clk/rst (sync, active high); inc = controller PC strobe (level, edge-detected here);
// load = take load_val instead of incrementing at a rise; pc = committed PC;
// pc_view = PC as memory should see it this cycle (next value during a rise).
module pc_counter #(
    parameter int             W         = 13,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_view
);

    logic         inc_d;
    logic         inc_rise;
    logic [W-1:0] next_pc;

    assign inc_rise = inc & ~inc_d;
    // Natural W-bit wrap: all-ones + 1 becomes zero.
    assign next_pc  = load ? load_val : pc + W'(1);
    // Lookahead so memory can present the next byte in the same cycle the strobe rises.
    assign pc_view  = inc_rise ? next_pc : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VAL;
            inc_d <= 1'b0;
        end else begin
            inc_d <= inc;
            if (inc_rise) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, two-byte instruction register, and memory address mux.
// Latency: OPCODE one cycle after the high-byte edge, IR_ADDR/INSTR_VALID one cycle after the low-byte edge.
// Backpressure: none; controller strobes are obeyed every cycle, INC_PC acts on its rising edge only.
//
// Ports: CLK1/RST (sync, active high); INC_PC, LOAD_PC, LOAD_IR, FETCH = controller strobes;
// DATA = async memory read data; OPCODE/IR_ADDR = captured instruction; PC_ADDR = committed PC;
// ADDR = memory address (IR_ADDR when FETCH, else PC with lookahead); INSTR_VALID = one-cycle done pulse.
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                OP_W     = cpu_pkg::OP_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK1,
    input  logic              RST,
    input  logic              INC_PC,
    input  logic              LOAD_PC,
    input  logic              LOAD_IR,
    input  logic              FETCH,
    input  logic [DATA_W-1:0] DATA,
    output logic [OP_W-1:0]   OPCODE,
    output logic [ADDR_W-1:0] IR_ADDR,
    output logic [ADDR_W-1:0] PC_ADDR,
    output logic [ADDR_W-1:0] ADDR,
    output logic              INSTR_VALID
);

    import cpu_pkg::fetch_phase_t;
    import cpu_pkg::PH_HI;
    import cpu_pkg::PH_LO;

    fetch_phase_t      phase;
    fetch_phase_t      phase_nxt;
    logic [OP_W-1:0]   opcode_nxt;
    logic [ADDR_W-1:0] ir_addr_nxt;
    logic              valid_nxt;
    logic [ADDR_W-1:0] pc_view;

    // PC loads from the committed IR_ADDR, never from a byte being captured this edge.
    pc_counter #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (CLK1),
        .rst      (RST),
        .inc      (INC_PC),
        .load     (LOAD_PC),
        .load_val (IR_ADDR),
        .pc       (PC_ADDR),
        .pc_view  (pc_view)
    );

    assign ADDR = FETCH ? IR_ADDR : pc_view;

    always_ff @(posedge CLK1) begin
        if (RST) begin
            phase       <= PH_HI;
            OPCODE      <= '0;
            IR_ADDR     <= '0;
            INSTR_VALID <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            OPCODE      <= opcode_nxt;
            IR_ADDR     <= ir_addr_nxt;
            INSTR_VALID <= valid_nxt;
        end
    end

    // High byte is {opcode, addr[ADDR_W-1:DATA_W]}, low byte is addr[DATA_W-1:0].
    // Any cycle without LOAD_IR abandons a half-captured instruction; the high-byte
    // fields keep whatever was captured.
    always_comb begin
        phase_nxt   = PH_HI;
        opcode_nxt  = OPCODE;
        ir_addr_nxt = IR_ADDR;
        valid_nxt   = 1'b0;
        if (LOAD_IR) begin
            case (phase)
                PH_HI: begin
                    opcode_nxt                     = DATA[DATA_W-1 -: OP_W];
                    ir_addr_nxt[ADDR_W-1:DATA_W]   = DATA[ADDR_W-DATA_W-1:0];
                    phase_nxt                      = PH_LO;
                end
                PH_LO: begin
                    ir_addr_nxt[DATA_W-1:0] = DATA;
                    valid_nxt               = 1'b1;
                    phase_nxt               = PH_HI;
                end
                default: phase_nxt = PH_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized strobes against a reference model.
// Latency: inputs driven at negedge; ADDR checked before the posedge, registers checked just after it.
// Backpressure: not applicable.
module tb_fetch_unit;

    logic        CLK1;
    logic        RST;
    logic        INC_PC;
    logic        LOAD_PC;
    logic        LOAD_IR;
    logic        FETCH;
    logic [7:0]  DATA;
    logic [2:0]  OPCODE;
    logic [12:0] IR_ADDR;
    logic [12:0] PC_ADDR;
    logic [12:0] ADDR;
    logic        INSTR_VALID;

    logic [7:0]  mem [0:8191];

    int checks = 0;
    int passed = 0;

    fetch_unit dut (
        .CLK1        (CLK1),
        .RST         (RST),
        .INC_PC      (INC_PC),
        .LOAD_PC     (LOAD_PC),
        .LOAD_IR     (LOAD_IR),
        .FETCH       (FETCH),
        .DATA        (DATA),
        .OPCODE      (OPCODE),
        .IR_ADDR     (IR_ADDR),
        .PC_ADDR     (PC_ADDR),
        .ADDR        (ADDR),
        .INSTR_VALID (INSTR_VALID)
    );

    // Asynchronous memory.
    assign DATA = mem[ADDR];

    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    task automatic drive(input logic r, input logic i, input logic lp, input logic li, input logic f);
        @(negedge CLK1);
        RST     = r;
        INC_PC  = i;
        LOAD_PC = lp;
        LOAD_IR = li;
        FETCH   = f;
    endtask

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 1);
        tick();
        drive(1, 1, 1, 1, 1);
        tick();
        checks++; if (PC_ADDR !== 13'h0) $display("FAIL reset_pc: got %h want 0000", PC_ADDR); else passed++;
        checks++; if (OPCODE !== 3'h0) $display("FAIL reset_opcode: got %h want 0", OPCODE); else passed++;
        checks++; if (IR_ADDR !== 13'h0) $display("FAIL reset_ir_addr: got %h want 0000", IR_ADDR); else passed++;
        checks++; if (INSTR_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", INSTR_VALID); else passed++;
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (ADDR !== 13'h0) $display("FAIL reset_addr: got %h want 0000", ADDR); else passed++;
        tick();
    endtask

    task automatic test_normal_fetch();
        mem[0] = 8'hA3;
        mem[1] = 8'h45;
        drive(0, 0, 0, 1, 0);
        #1;
        checks++; if (ADDR !== 13'h0) $display("FAIL fetch_addr_hi: got %h want 0000", ADDR); else passed++;
        tick();
        checks++; if (OPCODE !== cpu_pkg::LDA) $display("FAIL fetch_opcode: got %b want 101", OPCODE); else passed++;
        drive(0, 1, 0, 1, 0);
        #1;
        checks++; if (ADDR !== 13'h1) $display("FAIL fetch_addr_lookahead: got %h want 0001", ADDR); else passed++;
        tick();
        checks++; if (IR_ADDR !== 13'h0345) $display("FAIL fetch_ir_addr: got %h want 0345", IR_ADDR); else passed++;
        checks++; if (PC_ADDR !== 13'h1) $display("FAIL fetch_pc_after_lo: got %h want 0001", PC_ADDR); else passed++;
        checks++; if (INSTR_VALID !== 1'b1) $display("FAIL fetch_valid_pulse: got %b want 1", INSTR_VALID); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (INSTR_VALID !== 1'b0) $display("FAIL fetch_valid_single: got %b want 0", INSTR_VALID); else passed++;
        drive(0, 1, 0, 0, 0);
        tick();
        checks++; if (PC_ADDR !== 13'h2) $display("FAIL fetch_pc_final: got %h want 0002", PC_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_jump();
        mem[2] = 8'h1F;
        mem[3] = 8'h00;
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (IR_ADDR !== 13'h1F00) $display("FAIL jump_ir_addr: got %h want 1f00", IR_ADDR); else passed++;
        drive(0, 1, 1, 0, 0);
        #1;
        checks++; if (ADDR !== 13'h1F00) $display("FAIL jump_addr_lookahead: got %h want 1f00", ADDR); else passed++;
        tick();
        checks++; if (PC_ADDR !== 13'h1F00) $display("FAIL jump_pc: got %h want 1f00", PC_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        checks++; if (ADDR !== 13'h1F00) $display("FAIL jump_fetch_mux: got %h want 1f00", ADDR); else passed++;
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (ADDR !== 13'h1F01) $display("FAIL jump_pc_mux: got %h want 1f01", ADDR); else passed++;
        tick();
    endtask

    task automatic test_held_and_wrap();
        // INC_PC held 4 cycles; LOAD_PC joins after the rise and must do nothing.
        drive(0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 0, 0);
            tick();
        end
        checks++; if (PC_ADDR !== 13'h1F02) $display("FAIL held_inc_once: got %h want 1f02", PC_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        mem[13'h1F02] = 8'h1F;
        mem[13'h1F03] = 8'hFF;
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 0, 0);
        tick();
        checks++; if (PC_ADDR !== 13'h1FFF) $display("FAIL wrap_load_max: got %h want 1fff", PC_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        #1;
        checks++; if (ADDR !== 13'h0) $display("FAIL wrap_addr_lookahead: got %h want 0000", ADDR); else passed++;
        tick();
        checks++; if (PC_ADDR !== 13'h0) $display("FAIL wrap_pc: got %h want 0000", PC_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_abort();
        mem[0] = 8'h22;
        drive(0, 0, 0, 1, 0);
        tick();
        checks++; if (OPCODE !== 3'h1) $display("FAIL abort_hi_opcode: got %h want 1", OPCODE); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (INSTR_VALID !== 1'b0) $display("FAIL abort_no_valid: got %b want 0", INSTR_VALID); else passed++;
        checks++; if (IR_ADDR !== 13'h02FF) $display("FAIL abort_ir_kept: got %h want 02ff", IR_ADDR); else passed++;
        mem[0] = 8'hE7;
        mem[1] = 8'h45;
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 1, 0);
        tick();
        checks++; if (IR_ADDR !== 13'h0745) $display("FAIL abort_refetch_ir: got %h want 0745", IR_ADDR); else passed++;
        checks++; if (OPCODE !== 3'h7) $display("FAIL abort_refetch_op: got %h want 7", OPCODE); else passed++;
        checks++; if (INSTR_VALID !== 1'b1) $display("FAIL abort_refetch_valid: got %b want 1", INSTR_VALID); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        // PC is 1 here, mem[1]=45 -> high byte opcode 2.
        drive(0, 0, 0, 1, 0);
        tick();
        checks++; if (OPCODE !== 3'h2) $display("FAIL midrst_hi_opcode: got %h want 2", OPCODE); else passed++;
        drive(1, 0, 0, 0, 0);
        tick();
        checks++; if (PC_ADDR !== 13'h0) $display("FAIL midrst_pc: got %h want 0000", PC_ADDR); else passed++;
        checks++; if (OPCODE !== 3'h0) $display("FAIL midrst_opcode: got %h want 0", OPCODE); else passed++;
        drive(0, 0, 0, 1, 0);
        tick();
        checks++; if (OPCODE !== 3'h7) $display("FAIL midrst_next_is_hi: got %h want 7", OPCODE); else passed++;
        checks++; if (IR_ADDR !== 13'h0700) $display("FAIL midrst_ir_addr: got %h want 0700", IR_ADDR); else passed++;
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (INSTR_VALID !== 1'b0) $display("FAIL midrst_no_valid: got %b want 0", INSTR_VALID); else passed++;
    endtask

    // Reference model: PC as an integer modulo 8192, the instruction as opcode plus
    // an integer operand address, and a flag saying whether a high byte is pending.
    task automatic test_random();
        int  m_pc, m_op, m_ira, npc, ea, d;
        bit  m_prev, m_half, m_valid, rise;
        logic r, i, lp, li, f;
        for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
        drive(1, 0, 0, 0, 0);
        tick();
        m_pc = 0; m_op = 0; m_ira = 0; m_prev = 0; m_half = 0; m_valid = 0;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            i  = 1'($urandom_range(0, 1));
            lp = ($urandom_range(0, 3) == 0);
            li = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 4) == 0);
            drive(r, i, lp, li, f);
            #1;
            rise = i && !m_prev;
            npc  = lp ? m_ira : (m_pc + 1) % 8192;
            ea   = f ? m_ira : (rise ? npc : m_pc);
            checks++; if (ADDR !== ea[12:0]) $display("FAIL rand_addr[%0d]: got %h want %h", n, ADDR, ea[12:0]); else passed++;
            d = int'(mem[ea]);
            tick();
            if (r) begin
                m_pc = 0; m_op = 0; m_ira = 0; m_prev = 0; m_half = 0; m_valid = 0;
            end else begin
                if (rise) m_pc = npc;
                m_valid = li && m_half;
                if (li && !m_half) begin
                    m_op   = d / 32;
                    m_ira  = (m_ira % 256) + (d % 32) * 256;
                    m_half = 1;
                end else if (li) begin
                    m_ira  = (m_ira / 256) * 256 + d;
                    m_half = 0;
                end else begin
                    m_half = 0;
                end
                m_prev = i;
            end
            checks++; if (PC_ADDR !== m_pc[12:0]) $display("FAIL rand_pc[%0d]: got %h want %h", n, PC_ADDR, m_pc[12:0]); else passed++;
            checks++; if (OPCODE !== m_op[2:0]) $display("FAIL rand_opcode[%0d]: got %h want %h", n, OPCODE, m_op[2:0]); else passed++;
            checks++; if (IR_ADDR !== m_ira[12:0]) $display("FAIL rand_ir_addr[%0d]: got %h want %h", n, IR_ADDR, m_ira[12:0]); else passed++;
            checks++; if (INSTR_VALID !== m_valid) $display("FAIL rand_valid[%0d]: got %b want %b", n, INSTR_VALID, m_valid); else passed++;
        end
    endtask

    initial begin
        RST = 1'b1; INC_PC = 1'b0; LOAD_PC = 1'b0; LOAD_IR = 1'b0; FETCH = 1'b0;
        for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
        test_reset();
        test_normal_fetch();
        test_jump();
        test_held_and_wrap();
        test_abort();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
